// File: rtl/clk_rst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_ctrl_if
// Description : Runtime divide-ratio reload bus for clk_rst_ctrl.
//               The master issues a one-cycle load strobe with channel
//               select and new ratio; the slave (sequencer) consumes it.
// Revision    : 1.0  initial release
// ============================================================================
interface clk_rst_ctrl_if #(
  parameter int DIV_W = 8
) ();

  logic             div_load;
  logic [2:0]       div_sel;
  logic [DIV_W-1:0] div_val;

  modport master (output div_load, div_sel, div_val);
  modport slave  (input  div_load, div_sel, div_val);

endinterface
`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_ctrl
// Description : Clock-enable and reset sequencer between PLL and core.
//               Holds the core in reset until PLL lock has been stable for
//               LOCK_CYCLES, then generates NUM_CE clock-enable strobes with
//               per-channel, glitch-free reloadable divide ratios.
// Revision    : 1.0  initial release
// ============================================================================
module clk_rst_ctrl #(
  parameter int                        NUM_CE      = 2,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CE*DIV_W-1:0]   DIV_INIT    = {8'd2, 8'd2},
  parameter int                        LOCK_CYCLES = 1024,
  parameter int                        LOCK_W      = 11
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           locked,
  clk_rst_ctrl_if.slave       cfg,
  output logic [NUM_CE-1:0]   ce,
  output logic                rst_out,
  output logic                ready,
  output logic                lock_lost
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  localparam logic [LOCK_W-1:0] C_LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  logic              r_lock_meta;
  logic              r_lock_sync;
  logic              w_lk;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_rst_out;
  logic              r_ready;
  logic              r_lock_lost;
  logic              w_run;

  assign w_lk      = r_lock_sync;
  assign w_run     = (r_state == S_RUN);
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;

  // Two-flop synchroniser for the asynchronous PLL lock indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_WAIT_LOCK;
    else     r_state <= w_state_nxt;
  end

  // Sequencer next-state: wait for lock, qualify it, run until it drops
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_LOCK: if (w_lk) w_state_nxt = S_STABLE;
      S_STABLE: begin
        if (!w_lk)                          w_state_nxt = S_WAIT_LOCK;
        else if (r_lock_cnt == C_LOCK_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:       if (!w_lk) w_state_nxt = S_WAIT_LOCK;
      default:     w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  // Lock-stability counter: counts only while staying in STABLE, else clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_lock_cnt <= '0;
    else if ((r_state == S_STABLE) && (w_state_nxt == S_STABLE))
      r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
    else
      r_lock_cnt <= '0;
  end

  // Core reset / ready registered alongside the state; sticky lock-loss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_rst_out <= (w_state_nxt != S_RUN);
      r_ready   <= (w_state_nxt == S_RUN);
      if (w_run && !w_lk) r_lock_lost <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CE; gi++) begin : g_ch
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pending;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;
    logic             w_hit;
    logic             w_wrap;

    // A ratio of zero behaves as one (strobe every cycle)
    assign w_hit  = cfg.div_load && (cfg.div_sel == 3'(gi));
    assign w_last = (r_active == '0) ? '0 : (r_active - DIV_W'(1));
    assign w_wrap = w_run && (r_cnt == w_last);
    assign ce[gi] = w_wrap;

    // Period counter: idle at zero outside RUN, wraps on the last count
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_cnt <= '0;
      else if (!w_run || w_wrap) r_cnt <= '0;
      else                      r_cnt <= r_cnt + DIV_W'(1);
    end

    // Ratio reload: staged in pending, promoted only on a wrap so no period
    // is ever truncated or stretched; loads outside RUN take effect at once
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_active  <= DIV_INIT[gi*DIV_W +: DIV_W];
        r_pending <= DIV_INIT[gi*DIV_W +: DIV_W];
      end else if (!w_run) begin
        if (w_hit) begin
          r_active  <= cfg.div_val;
          r_pending <= cfg.div_val;
        end
      end else begin
        if (w_hit)  r_pending <= cfg.div_val;
        if (w_wrap) r_active  <= w_hit ? cfg.div_val : r_pending;
      end
    end
  end

endmodule
`default_nettype wire
